rotate_seq_ctrl: RTL and testbench

ROTATE_SEQ_CTRL -- requirements
Module: rotate_seq_ctrl

---
 rtl/rotate_pkg.sv | 14 +
 rtl/rotate_step_cnt.sv | 38 +++
 rtl/rotate_seq_ctrl.sv | 86 ++++++++
 tb/tb_rotate_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rotate_pkg.sv
// Shared types and defaults for the rotate sequencing controller.
package rotate_pkg;

  localparam int unsigned DefDw = 4;
  localparam int unsigned DefSw = 3;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StLoad   = 2'd1;
  localparam state_t StRotate = 2'd2;
  localparam state_t StDone   = 2'd3;

endpackage

// File: rtl/rotate_step_cnt.sv
// Down-counter for remaining rotate steps; loadable, saturates at zero.
module rotate_step_cnt #(
  parameter int unsigned SW = 3
) (
  input  logic          clk,
  input  logic          sync_rst,
  input  logic          ld_i,
  input  logic [SW-1:0] ld_val_i,
  input  logic          dec_i,
  output logic          is_one_o,
  output logic          is_zero_o
);

  localparam logic [SW-1:0] One = SW'(1);

  logic [SW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - One;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_one_o  = (cnt_q == One);
  assign is_zero_o = (cnt_q == '0);

endmodule

// File: rtl/rotate_seq_ctrl.sv
// Sequences load/rotate strobes for a downstream right-rotate register.
// Optional abort input enabled by defining ROTATE_ABORT_EN.
module rotate_seq_ctrl
  import rotate_pkg::*;
#(
  parameter int unsigned DW = DefDw,
  parameter int unsigned SW = DefSw
) (
  input  logic          clk,
  input  logic          sync_rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [SW-1:0] in_steps,
  output logic          load,
  output logic          en,
  output logic [DW-1:0] data,
  output logic          busy,
  output logic          done
`ifdef ROTATE_ABORT_EN
  ,
  input  logic          abort
`endif
);

  state_t        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic          accept;
  logic          cnt_one, cnt_zero;

  // in_ready is masked by reset so a reset cycle can never complete a handshake.
  assign in_ready = (state_q == StIdle) && !sync_rst;
  assign accept   = in_valid && in_ready;

  rotate_step_cnt #(
    .SW(SW)
  ) u_step_cnt (
    .clk      (clk),
    .sync_rst (sync_rst),
    .ld_i     (accept),
    .ld_val_i (in_steps),
    .dec_i    (state_q == StRotate),
    .is_one_o (cnt_one),
    .is_zero_o(cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StLoad;
          data_d  = in_data;
        end
      end
      StLoad:   state_d = cnt_zero ? StDone : StRotate;
      StRotate: if (cnt_one) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
`ifdef ROTATE_ABORT_EN
    // Abort drops the operation but keeps the captured word on data.
    if (abort && ((state_q == StLoad) || (state_q == StRotate))) begin
      state_d = StIdle;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q <= StIdle;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign load = (state_q == StLoad);
  assign en   = (state_q == StRotate);
  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign data = data_q;

endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// Bench for rotate_seq_ctrl driving a right-rotate register; ROTATE_ABORT_EN adds abort tests.
module tb_rotate_seq_ctrl;
  import rotate_pkg::*;

  logic       clk = 1'b0;
  logic       sync_rst, in_valid, in_ready, load, en, busy, done;
  logic [3:0] in_data, data, q;
  logic [2:0] in_steps;
`ifdef ROTATE_ABORT_EN
  logic       abort;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rotate_seq_ctrl #(
    .DW(4),
    .SW(3)
  ) dut (
    .clk     (clk),
    .sync_rst(sync_rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .in_steps(in_steps),
    .load    (load),
    .en      (en),
    .data    (data),
    .busy    (busy),
    .done    (done)
`ifdef ROTATE_ABORT_EN
    ,
    .abort   (abort)
`endif
  );

  // Downstream right-rotate register sharing clk and sync_rst.
  always @(posedge clk) begin
    if (sync_rst)  q <= 4'b0000;
    else if (load) q <= data;
    else if (en)   q <= {q[0], q[3:1]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Presents one word, then counts strobes until done and checks the result.
  task automatic run_word(input logic [3:0] d, input logic [2:0] s, input logic [3:0] exp_q,
                          input string tag);
    int loads = 0, ens = 0, cyc = 0, overlap = 0, dchg = 0, w = 0;
    bit seen_done = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_steps = s;
    while (!in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    check({tag, " ready"}, 32'(in_ready), 32'd1);
    if (!in_ready) return;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~d;
    in_steps = ~s;
    for (int i = 0; i < 20 && !seen_done; i++) begin
      @(negedge clk);
      cyc++;
      if (load) loads++;
      if (en) ens++;
      if (load && en) overlap++;
      if (data !== d) dchg++;
      if (done) begin
        seen_done = 1;
        check({tag, " q"}, 32'(q), 32'(exp_q));
      end
    end
    check({tag, " done_seen"}, 32'(seen_done), 32'd1);
    check({tag, " loads"}, loads, 32'd1);
    check({tag, " ens"}, ens, 32'(s));
    check({tag, " cycles"}, cyc, 32'(s) + 32'd2);
    check({tag, " overlap"}, overlap, 32'd0);
    check({tag, " data_held"}, dchg, 32'd0);
    @(negedge clk);
    check({tag, " ready_after"}, 32'(in_ready), 32'd1);
    check({tag, " busy_after"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [3:0] d;
    logic [2:0] s;
    logic [3:0] exp_q;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] seq_q[4];
    int   cyc, dchg, rdy, dn;
    bit   seen;

    vecs[0] = '{d: 4'b1011, s: 3'd3, exp_q: 4'b0111};
    vecs[1] = '{d: 4'b0110, s: 3'd0, exp_q: 4'b0110};
    vecs[2] = '{d: 4'b0001, s: 3'd7, exp_q: 4'b0010};
    vecs[3] = '{d: 4'b1000, s: 3'd1, exp_q: 4'b0100};
    vecs[4] = '{d: 4'b1001, s: 3'd2, exp_q: 4'b0110};
    vecs[5] = '{d: 4'b0011, s: 3'd4, exp_q: 4'b0011};
    vecs[6] = '{d: 4'b1110, s: 3'd5, exp_q: 4'b0111};
    seq_q   = '{4'b1011, 4'b1101, 4'b1110, 4'b0111};

    // Reset with in_valid asserted: nothing may be captured.
    sync_rst = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'b1111;
    in_steps = 3'd3;
`ifdef ROTATE_ABORT_EN
    abort = 1'b0;
`endif
    @(negedge clk);
    check("rst in_ready c1", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("rst in_ready c2", 32'(in_ready), 32'd0);
    sync_rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst load", 32'(load), 32'd0);
    check("post_rst en", 32'(en), 32'd0);
    check("post_rst done", 32'(done), 32'd0);
    check("post_rst busy", 32'(busy), 32'd0);
    check("post_rst data", 32'(data), 32'd0);
    check("post_rst in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 7; i++) begin
      run_word(vecs[i].d, vecs[i].s, vecs[i].exp_q, $sformatf("vec%0d", i));
    end

    // Cycle-exact q trace for 1011 rotated 3 times.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'b1011;
    in_steps = 3'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("trace load", 32'({load, en}), 32'b10);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("trace q%0d", i), 32'(q), 32'(seq_q[i]));
      check($sformatf("trace en%0d", i), 32'(en), (i < 3) ? 32'd1 : 32'd0);
    end
    check("trace done", 32'(done), 32'd1);

    // Back-to-back: in_valid held, second word must wait for IDLE.
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'b0001;
    in_steps = 3'd7;
    @(posedge clk);
    #1;
    in_data  = 4'b1000;
    in_steps = 3'd1;
    cyc  = 0;
    dchg = 0;
    rdy  = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (data !== 4'b0001) dchg++;
      if (in_ready) rdy++;
      if (done) seen = 1;
    end
    check("b2b first done", 32'(seen), 32'd1);
    check("b2b first cycles", cyc, 32'd9);
    check("b2b no capture", dchg, 32'd0);
    check("b2b not ready", rdy, 32'd0);
    check("b2b first q", 32'(q), 32'b0010);
    @(negedge clk);
    check("b2b idle ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b second load", 32'(load), 32'd1);
    check("b2b second data", 32'(data), 32'b1000);
    @(negedge clk);
    check("b2b second en", 32'(en), 32'd1);
    @(negedge clk);
    check("b2b second done", 32'(done), 32'd1);
    check("b2b second q", 32'(q), 32'b0100);

    // Reset in the second ROTATE cycle abandons the word.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'b1011;
    in_steps = 3'd5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst rot1 en", 32'(en), 32'd1);
    @(negedge clk);
    check("midrst rot2 en", 32'(en), 32'd1);
    sync_rst = 1'b1;
    @(negedge clk);
    sync_rst = 1'b0;
    check("midrst en", 32'(en), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst data", 32'(data), 32'd0);
    check("midrst q", 32'(q), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("midrst no done", dn, 32'd0);
    check("midrst ready", 32'(in_ready), 32'd1);

`ifdef ROTATE_ABORT_EN
    // Abort in the first ROTATE cycle returns to IDLE keeping the word.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'b1011;
    in_steps = 3'd5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort rot1 en", 32'(en), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort ready", 32'(in_ready), 32'd1);
    check("abort data", 32'(data), 32'b1011);
    check("abort done", 32'(done), 32'd0);
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort no done", dn, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
